posit_div_seq: RTL and testbench
================================

Name: posit_div_seq

Overview:
- Sequential posit divider: out = in1 / in2 for posit<N,es>.
- Inverse companion to the combinational posit multiplier in the posit_op unit.
- Same operand/flag interface style (in1, in2, start, out, inf, zero, done), plus a clock and busy.
- Uses a restoring radix-2 mantissa divider that produces one quotient bit per cycle. Latency is fixed, which keeps issue logic simple.

Parameters:
- N, 32, posit word width.
- es, 2, exponent field width.
- Bs, log2(N), regime-count width (derived).
- QW, N-es+3, quotient bits generated (hidden + fraction + guard + round).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset.
- in1  input  N  dividend posit, sampled on the start cycle.
- in2  input  N  divisor posit, sampled on the start cycle.
- start  input  1  request pulse; honoured only when busy=0.
- out  output  N  quotient posit; held stable from done until the next accepted start.
- inf  output  1  result is NaR; valid with done, held with out.
- zero  output  1  result is zero; valid with done, held with out.
- done  output  1  one-cycle pulse: out/inf/zero are valid.
- busy  output  1  high from the accepted start until the done cycle, inclusive.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset value of every output (out, inf, zero, done, busy) is 0; FSM returns to IDLE. Reset mid-operation aborts the division; no done is produced.
- FSM states and transitions:
  - IDLE -> UNPACK on start.
  - UNPACK -> DIV, 1 cycle.
  - DIV -> ROUND after QW cycles.
  - ROUND -> IDLE, 1 cycle.
  - done pulses in the ROUND->IDLE cycle.
- Latency: done is asserted exactly QW+2 cycles after the start edge (35 for N=32, es=2).
- start while busy=1 is ignored; operands are not re-sampled. start in the done cycle is also ignored, because busy is still 1.
- UNPACK:
  - Sign, inf and zero detection as in the multiplier convention.
  - Two's-complement magnitude; regime, exp and mantissa extracted with hidden bit 1.
  - Scale = 4*k + e, Bs+es+2-bit signed (generally 2^es*k + e).
- DIV:
  - Remainder register N-es+2 bits; quotient register QW bits.
  - Each cycle: trial-subtract the divisor mantissa, shift in the quotient bit.
  - Quotient lies in (0.5, 2). If its MSB is 0, shift left 1 and decrement the scale.
- Result scale = s1 - s2 - norm_adj.
- Sticky bit = OR of the final remainder.
- ROUND:
  - Pack regime/exp/fraction.
  - Round to nearest even using L, G, R and St, as in the multiplier.
  - Negate if s1^s2.
- Saturation: |result| > maxpos gives ±maxpos (0x7FFFFFFF); a nonzero result < minpos gives ±minpos (0x00000001). The result never rounds to 0 or NaR.
- Special cases still take full latency (unless the optional feature below is enabled):
  - in1 or in2 NaR, or in2 zero -> out=0x80000000, inf=1.
  - in1 zero with in2 finite nonzero -> out=0, zero=1.
  - Otherwise inf=zero=0.

Optional Feature:
- POSIT_DIV_EARLY_EXIT_EN.
- Defined: special cases (NaR or zero operands) skip DIV and ROUND. done asserts 2 cycles after start (UNPACK -> DONE). busy drops accordingly.
- Undefined: all operations take QW+2 cycles.

Decomposition:
- Package posit_pkg holds:
  - N, ES, BS constants.
  - NAR and MAXPOS constants.
  - state enum {IDLE, UNPACK, DIV, ROUND}.
- Natural sub-module: posit_unpack (sign strip, regime leading-one detect, exp/mantissa extract), instantiated twice.
- Divider datapath and packing stay in the top module.

Test Plan:
- 0x48000000 / 0x40000000 (2/1) -> out=0x48000000, done exactly 35 cycles after start, busy high throughout.
- 0x40000000 / 0x48000000 (1/2) -> 0x38000000; 0xC0000000 / 0x50000000 (-1/4) -> 0xD0000000.
- 0x40000000 / 0x4C000000 (1/3) -> 0x32AAAAAB (checks the RNE round-up path).
- 0x3F000000 / 0x00000000 -> 0x80000000, inf=1. 0x00000000 / 0x40000000 -> 0x00000000, zero=1. Latency is 2 cycles with POSIT_DIV_EARLY_EXIT_EN, else 35.
- 0x7FFFFFFF / 0x00000001 -> 0x7FFFFFFF (saturate); 0x00000001 / 0x7FFFFFFF -> 0x00000001.
- start re-pulsed with new operands at cycle 10 -> ignored, original result returned. Assert rst_i at cycle 20 -> all outputs 0, no done; a subsequent start computes correctly.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared constants, FSM states and the unpacked-operand record for the posit<32,2> divider.
package posit_pkg;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int BS = $clog2(N);
  localparam int SW = BS + ES + 2;   // scale width: {k, e}
  localparam int MW = N - ES;        // mantissa incl. hidden bit
  localparam int RW = N - ES + 2;    // remainder width
  localparam int QW = N - ES + 3;    // quotient bits produced
  localparam int CW = $clog2(QW);

  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, UNPACK, DIV, ROUND} state_t;

  typedef struct packed {
    logic          sgn;
    logic          nar;
    logic          zro;
    logic [SW-1:0] scale;  // two's complement 4*k + e
    logic [MW-1:0] mant;   // 1.fff
  } unp_t;
endpackage

// File: rtl/posit_div_seq_if.sv
// Operand/result handshake bundle of the sequential posit divider.
interface posit_div_seq_if;
  import posit_pkg::*;
  logic [N-1:0] in1, in2, out;
  logic         start, inf, zero, done, busy;

  modport master (output in1, in2, start, input out, inf, zero, done, busy);
  modport slave  (input in1, in2, start, output out, inf, zero, done, busy);
endinterface

// File: rtl/posit_unpack.sv
// Posit field decode: sign strip, regime run-length, exponent and hidden-bit mantissa.
module posit_unpack
  import posit_pkg::*;
(
  input  logic [N-1:0] x,
  output unp_t         u
);
  logic [N-2:0] r, sh;
  logic [BS:0]  run;
  logic [BS+1:0] run_x, k;
  logic         hit;

  always_comb begin
    r   = x[N-1] ? (~x[N-2:0] + (N-1)'(1)) : x[N-2:0];
    run = '0;
    hit = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!hit && (r[i] == r[N-2])) run = run + (BS+1)'(1);
      else                          hit = 1'b1;
    end
    run_x = {1'b0, run};
    k     = r[N-2] ? (run_x - (BS+2)'(1)) : -run_x;
    // drop regime run and its terminator; a full-width run leaves nothing
    sh    = r << (run + (BS+1)'(1));
    u.sgn   = x[N-1];
    u.nar   = (x == NAR);
    u.zro   = (x == '0);
    u.scale = {k, sh[N-2 -: ES]};
    u.mant  = {1'b1, sh[N-2-ES:0]};
  end
endmodule

// File: rtl/posit_div_seq.sv
// Sequential posit divider, restoring radix-2, one quotient bit per cycle.
// Define POSIT_DIV_EARLY_EXIT_EN to let NaR/zero operands bypass the divide loop.
module posit_div_seq
  import posit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  posit_div_seq_if.slave    bus
);
  localparam int FW = QW - 1;
  localparam int XW = 1 + ES + FW;
  localparam int BW = N - 1 + XW;
  localparam logic signed [SW:0] KHI = (SW+1)'(N - 2);
  localparam logic signed [SW:0] KLO = -KHI;

  state_t state, nxt;
  logic [1:0][N-1:0] op;
  unp_t              u [2];
  logic [RW-1:0]     rem, diff;
  logic [MW-1:0]     dvs;
  logic [QW-1:0]     q;
  logic [CW-1:0]     cnt;
  logic signed [SW:0] scl, sc, kr;
  logic              sgn, sp_inf, sp_zero, sp_inf_c, sp_zero_c, accept, ge;
  logic [FW-1:0]     qn;
  logic [BS:0]       len, lsh;
  logic [BW-1:0]     big;
  logic [N-1:0]      rnd, mag_r, fin;
  logic              g, l, st;

  for (genvar i = 0; i < 2; i++) begin : g_unp
    posit_unpack u_unp (.x(op[i]), .u(u[i]));
  end

  assign accept    = bus.start && !bus.busy && (state == IDLE);
  assign sp_inf_c  = u[0].nar || u[1].nar || u[1].zro;
  assign sp_zero_c = u[0].zro && !sp_inf_c;
  assign ge        = rem >= {2'b00, dvs};
  assign diff      = ge ? (rem - {2'b00, dvs}) : rem;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (accept) nxt = UNPACK;
`ifdef POSIT_DIV_EARLY_EXIT_EN
      UNPACK: nxt = (sp_inf_c || sp_zero_c) ? ROUND : DIV;
`else
      UNPACK: nxt = DIV;
`endif
      DIV:    if (cnt == CW'(QW - 1)) nxt = ROUND;
      ROUND:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Normalise, build the regime/exp/fraction string, round to nearest even.
  always_comb begin
    qn    = q[QW-1] ? q[FW-1:0] : {q[FW-2:0], 1'b0};
    sc    = scl - (q[QW-1] ? (SW+1)'(0) : (SW+1)'(1));
    kr    = sc >>> ES;
    len   = kr[SW] ? (BS+1)'(-kr) : ((BS+1)'(kr) + (BS+1)'(1));
    lsh   = (BS+1)'(N - 1) - len;
    big   = {{(N-1){~kr[SW]}}, kr[SW], sc[ES-1:0], qn} << lsh;
    l     = big[BW-N+1];
    g     = big[BW-N];
    st    = (|big[BW-N-1:0]) || (|rem);
    rnd   = {1'b0, big[BW-1 -: N-1]} + N'(g && (l || st));
    if (kr >= KHI)     mag_r = MAXPOS;
    else if (kr < KLO) mag_r = MINPOS;
    else if (rnd == '0) mag_r = MINPOS;
    else               mag_r = rnd;
    if (sp_inf)        fin = NAR;
    else if (sp_zero)  fin = '0;
    else               fin = sgn ? -mag_r : mag_r;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      op <= '0; rem <= '0; dvs <= '0; q <= '0; cnt <= '0; scl <= '0;
      sgn <= 1'b0; sp_inf <= 1'b0; sp_zero <= 1'b0;
      bus.out <= '0; bus.inf <= 1'b0; bus.zero <= 1'b0;
      bus.done <= 1'b0; bus.busy <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept)        bus.busy <= 1'b1;
      else if (bus.done) bus.busy <= 1'b0;
      case (state)
        IDLE: if (accept) op <= {bus.in2, bus.in1};
        UNPACK: begin
          rem     <= {2'b00, u[0].mant};
          dvs     <= u[1].mant;
          scl     <= $signed({u[0].scale[SW-1], u[0].scale}) - $signed({u[1].scale[SW-1], u[1].scale});
          sgn     <= u[0].sgn ^ u[1].sgn;
          sp_inf  <= sp_inf_c;
          sp_zero <= sp_zero_c;
          q       <= '0;
          cnt     <= '0;
        end
        DIV: begin
          rem <= {diff[RW-2:0], 1'b0};
          q   <= {q[QW-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        ROUND: begin
          bus.done <= 1'b1;
          bus.out  <= fin;
          bus.inf  <= sp_inf;
          bus.zero <= sp_zero;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_posit_div_seq.sv
// Directed bench for posit_div_seq: hand-computed quotients, latency, busy, abort and re-start.
module tb_posit_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  posit_div_seq_if bus();
  posit_div_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam int LAT = 35;
`ifdef POSIT_DIV_EARLY_EXIT_EN
  localparam int SPLAT = 2;
`else
  localparam int SPLAT = 35;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded), counting cycles from the start edge.
  task automatic wait_done(output int cyc, output bit bz);
    cyc = 0; bz = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      bz &= (bus.busy === 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_out, input logic e_inf, input logic e_zero, input int e_lat);
    int cyc; bit bz;
    issue(a, b);
    wait_done(cyc, bz);
    chk({tag, ".lat"},  32'(cyc), 32'(e_lat));
    chk({tag, ".out"},  bus.out, e_out);
    chk({tag, ".inf"},  32'(bus.inf), 32'(e_inf));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(e_zero));
    chk({tag, ".busy"}, 32'(bz && bus.busy === 1'b1), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_off"},   32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc; bit bz; bit seen;
    bus.in1 = '0; bus.in2 = '0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",  bus.out, 32'h0);
    chk("rst.inf",  32'(bus.inf), 32'd0);
    chk("rst.zero", 32'(bus.zero), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("2div1",   32'h48000000, 32'h40000000, 32'h48000000, 1'b0, 1'b0, LAT);
    run("1div2",   32'h40000000, 32'h48000000, 32'h38000000, 1'b0, 1'b0, LAT);
    run("m1div4",  32'hC0000000, 32'h50000000, 32'hD0000000, 1'b0, 1'b0, LAT);
    run("1div3",   32'h40000000, 32'h4C000000, 32'h32AAAAAB, 1'b0, 1'b0, LAT);
    run("xdiv0",   32'h3F000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, SPLAT);
    run("0divx",   32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, SPLAT);
    run("nardiv",  32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b0, SPLAT);
    run("satmax",  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, LAT);
    run("satmin",  32'h00000001, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, LAT);

    // start re-pulsed mid-operation with different operands must be ignored
    issue(32'h48000000, 32'h40000000);
    cyc = 0; bz = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == 10) begin
        bus.in1 = 32'h40000000; bus.in2 = 32'h4C000000; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("repulse.lat", 32'(cyc), 32'(LAT));
    chk("repulse.out", bus.out, 32'h48000000);
    @(posedge clk); #1;

    // asynchronous reset mid-division aborts it
    issue(32'h40000000, 32'h4C000000);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort.out",  bus.out, 32'h0);
    chk("abort.inf",  32'(bus.inf), 32'd0);
    chk("abort.zero", 32'(bus.zero), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("abort.nodone", 32'(seen), 32'd0);
    run("after_rst", 32'h40000000, 32'h4C000000, 32'h32AAAAAB, 1'b0, 1'b0, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
